// File: rtl/periph_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_responder_pkg
// Description : Shared definitions for the peripheral responder. Holds the
//               request/response codes, the STATUS word bit positions and a
//               helper that packs the STATUS word.
// Revision    : 1.0 - initial release
// ============================================================================
package periph_responder_pkg;

  // Request codes carried on to_peripheral
  typedef enum logic [1:0] {
    PERIPH_REQ_NOP    = 2'b00,
    PERIPH_REQ_WRITE  = 2'b01,
    PERIPH_REQ_READ   = 2'b10,
    PERIPH_REQ_STATUS = 2'b11
  } periph_req_e;

  // Response codes returned on from_peripheral
  typedef enum logic [1:0] {
    PERIPH_RSP_NONE = 2'b00,
    PERIPH_RSP_ACK  = 2'b01,
    PERIPH_RSP_NACK = 2'b10,
    PERIPH_RSP_STAT = 2'b11
  } periph_rsp_e;

  // STATUS word layout
  localparam int unsigned C_STAT_EG_FULL_BIT  = 0;
  localparam int unsigned C_STAT_IN_EMPTY_BIT = 1;
  localparam int unsigned C_STAT_EG_CNT_LSB   = 8;
  localparam int unsigned C_STAT_IN_CNT_LSB   = 16;

  function automatic logic [31:0] pack_status(
    input logic [7:0] in_cnt,
    input logic [7:0] eg_cnt,
    input logic       in_empty,
    input logic       eg_full
  );
    logic [31:0] w;
    w = '0;
    w[C_STAT_IN_CNT_LSB +: 8] = in_cnt;
    w[C_STAT_EG_CNT_LSB +: 8] = eg_cnt;
    w[C_STAT_IN_EMPTY_BIT]    = in_empty;
    w[C_STAT_EG_FULL_BIT]     = eg_full;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/periph_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : periph_sync_fifo
// Description : Single-clock FIFO with occupancy count. Push is ignored when
//               full, pop is ignored when empty. Head reads 0 while empty.
// Ports       : clk, rst (async, active-high)
//               i_push/i_push_data - write side
//               i_pop              - advance head
//               o_full/o_empty/o_count/o_head - state of the queue
// Revision    : 1.0 - initial release
// ============================================================================
module periph_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage carries no reset; contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/periph_responder.sv
`default_nettype none
// ============================================================================
// Module      : periph_responder
// Description : Responder end of the core peripheral port. Decodes one
//               request per cycle and returns a registered response exactly
//               one cycle later. WRITE data goes to an egress FIFO drained by
//               a sink; READ data comes from an ingress FIFO filled by a
//               source.
// Config      : PERIPH_LOOPBACK_EN - when defined, ACKed WRITE data is looped
//               into the ingress FIFO, source/sink ports are idle and the
//               egress FIFO is not built.
// Ports       : clock, reset (async, active-high)
//               to_peripheral*   - request from core
//               from_peripheral* - response to core
//               src_*            - ingress source handshake
//               snk_*            - egress sink handshake
// Revision    : 1.0 - initial release
// ============================================================================
module periph_responder
  import periph_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] snk_data,
  output logic                  snk_valid,
  input  logic                  snk_ready
);

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wr_full;
  logic                  w_wr_ok;

  logic                  w_in_push;
  logic [DATA_WIDTH-1:0] w_in_push_data;
  logic                  w_in_pop;
  logic                  w_in_full;
  logic                  w_in_empty;
  logic [CNT_W-1:0]      w_in_count;
  logic [DATA_WIDTH-1:0] w_in_head;

  logic                  w_eg_full;
  logic [CNT_W-1:0]      w_eg_count;

  periph_rsp_e           w_rsp_code;
  logic [DATA_WIDTH-1:0] w_rsp_data;
  logic                  w_rsp_valid;
  logic [31:0]           w_status;

  logic [1:0]            r_rsp_code;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_valid;

  assign w_wr_req = to_peripheral_valid && (to_peripheral == PERIPH_REQ_WRITE);
  assign w_rd_req = to_peripheral_valid && (to_peripheral == PERIPH_REQ_READ);
  // Full/empty come straight from registered FIFO state, so same-cycle
  // sink pops or source pushes never turn a NACK into an ACK.
  assign w_wr_ok  = w_wr_req & ~w_wr_full;
  assign w_in_pop = w_rd_req & ~w_in_empty;

`ifdef PERIPH_LOOPBACK_EN
  logic w_unused_loopback;

  assign w_in_push         = w_wr_ok;
  assign w_in_push_data    = to_peripheral_data;
  assign w_wr_full         = w_in_full;
  assign src_ready         = 1'b0;
  assign snk_valid         = 1'b0;
  assign snk_data          = '0;
  assign w_eg_full         = 1'b0;
  assign w_eg_count        = '0;
  assign w_unused_loopback = ^{src_data, src_valid, snk_ready};
`else
  logic w_eg_empty;

  assign src_ready      = ~w_in_full;
  assign w_in_push      = src_valid & ~w_in_full;
  assign w_in_push_data = src_data;
  assign w_wr_full      = w_eg_full;
  assign snk_valid      = ~w_eg_empty;

  periph_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_egress (
    .clk         (clock),
    .rst         (reset),
    .i_push      (w_wr_ok),
    .i_push_data (to_peripheral_data),
    .i_pop       (snk_ready & ~w_eg_empty),
    .o_full      (w_eg_full),
    .o_empty     (w_eg_empty),
    .o_count     (w_eg_count),
    .o_head      (snk_data)
  );
`endif

  periph_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_ingress (
    .clk         (clock),
    .rst         (reset),
    .i_push      (w_in_push),
    .i_push_data (w_in_push_data),
    .i_pop       (w_in_pop),
    .o_full      (w_in_full),
    .o_empty     (w_in_empty),
    .o_count     (w_in_count),
    .o_head      (w_in_head)
  );

  // Counts are at most 8 bits wide for the supported depth range.
  assign w_status = pack_status(8'(w_in_count), 8'(w_eg_count),
                                w_in_empty, w_eg_full);

  always_comb begin
    w_rsp_code  = PERIPH_RSP_NONE;
    w_rsp_data  = '0;
    w_rsp_valid = 1'b0;
    if (to_peripheral_valid) begin
      case (to_peripheral)
        PERIPH_REQ_WRITE: begin
          w_rsp_valid = 1'b1;
          w_rsp_code  = w_wr_full ? PERIPH_RSP_NACK : PERIPH_RSP_ACK;
        end
        PERIPH_REQ_READ: begin
          w_rsp_valid = 1'b1;
          w_rsp_code  = w_in_empty ? PERIPH_RSP_NACK : PERIPH_RSP_ACK;
          w_rsp_data  = w_in_empty ? '0 : w_in_head;
        end
        PERIPH_REQ_STATUS: begin
          w_rsp_valid = 1'b1;
          w_rsp_code  = PERIPH_RSP_STAT;
          w_rsp_data  = DATA_WIDTH'(w_status);
        end
        default: begin
          w_rsp_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_code  <= PERIPH_RSP_NONE;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_code  <= w_rsp_code;
      r_rsp_data  <= w_rsp_data;
      r_rsp_valid <= w_rsp_valid;
    end
  end

  assign from_peripheral       = r_rsp_code;
  assign from_peripheral_data  = r_rsp_data;
  assign from_peripheral_valid = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_periph_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_responder
// Description : Self-checking bench for periph_responder. One vector per
//               clock: inputs are applied, and the registered response plus
//               the FIFO handshake outputs are compared just after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_responder;

  localparam int C_DW = 32;

  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_WR  = 2'b01;
  localparam logic [1:0] C_RD  = 2'b10;
  localparam logic [1:0] C_ST  = 2'b11;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_ACK  = 2'b01;
  localparam logic [1:0] C_NACK = 2'b10;
  localparam logic [1:0] C_STAT = 2'b11;

  typedef struct {
    logic        rv;
    logic [1:0]  rq;
    logic [31:0] rd;
    logic        sv;
    logic [31:0] sd;
    logic        sr;
    logic        ev;
    logic [1:0]  er;
    logic [31:0] ed;
    logic        esv;
    logic [31:0] esd;
    logic        esr;
  } vec_t;

  logic            clock;
  logic            reset;
  logic [1:0]      to_peripheral;
  logic [C_DW-1:0] to_peripheral_data;
  logic            to_peripheral_valid;
  logic [1:0]      from_peripheral;
  logic [C_DW-1:0] from_peripheral_data;
  logic            from_peripheral_valid;
  logic [C_DW-1:0] src_data;
  logic            src_valid;
  logic            src_ready;
  logic [C_DW-1:0] snk_data;
  logic            snk_valid;
  logic            snk_ready;

  int n_checks;
  int n_fail;

  vec_t        tbl[$];
  logic [31:0] model[$];

  periph_responder #(
    .DATA_WIDTH (C_DW),
    .FIFO_DEPTH (8)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .to_peripheral         (to_peripheral),
    .to_peripheral_data    (to_peripheral_data),
    .to_peripheral_valid   (to_peripheral_valid),
    .from_peripheral       (from_peripheral),
    .from_peripheral_data  (from_peripheral_data),
    .from_peripheral_valid (from_peripheral_valid),
    .src_data              (src_data),
    .src_valid             (src_valid),
    .src_ready             (src_ready),
    .snk_data              (snk_data),
    .snk_valid             (snk_valid),
    .snk_ready             (snk_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(
    input logic rv, input logic [1:0] rq, input logic [31:0] rd,
    input logic sv, input logic [31:0] sd, input logic sr,
    input logic ev, input logic [1:0] er, input logic [31:0] ed,
    input logic esv, input logic [31:0] esd, input logic esr
  );
    vec_t v;
    v.rv = rv; v.rq = rq; v.rd = rd;
    v.sv = sv; v.sd = sd; v.sr = sr;
    v.ev = ev; v.er = er; v.ed = ed;
    v.esv = esv; v.esd = esd; v.esr = esr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [1:0] rq, input logic [31:0] rd,
                       input logic sv, input logic [31:0] sd, input logic sr);
    to_peripheral_valid = rv;
    to_peripheral       = rq;
    to_peripheral_data  = rd;
    src_valid           = sv;
    src_data            = sd;
    snk_ready           = sr;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_rsp(input string nm, input logic ev, input logic [1:0] er,
                         input logic [31:0] ed);
    chk(nm, {29'd0, from_peripheral_valid, from_peripheral, from_peripheral_data},
            {29'd0, ev, er, ed});
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive(v.rv, v.rq, v.rd, v.sv, v.sd, v.sr);
    chk_rsp($sformatf("vec%0d_rsp", idx), v.ev, v.er, v.ed);
    chk($sformatf("vec%0d_port", idx), {30'd0, snk_valid, snk_data, src_ready},
                                       {30'd0, v.esv, v.esd, v.esr});
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    reset               = 1'b1;
    to_peripheral       = C_NOP;
    to_peripheral_data  = '0;
    to_peripheral_valid = 1'b0;
    src_data            = '0;
    src_valid           = 1'b0;
    snk_ready           = 1'b0;

    #12;
    chk_rsp("reset_rsp", 1'b0, C_NONE, 32'h0);
`ifdef PERIPH_LOOPBACK_EN
    chk("reset_port", {30'd0, snk_valid, snk_data, src_ready}, {30'd0, 1'b0, 32'h0, 1'b0});
`else
    chk("reset_port", {30'd0, snk_valid, snk_data, src_ready}, {30'd0, 1'b0, 32'h0, 1'b1});
`endif
    reset = 1'b0;

`ifdef PERIPH_LOOPBACK_EN
    tbl.push_back(mk(1, C_ST,  0, 0, 0, 0,          1, C_STAT, 32'h0000_0002, 0, 0, 0));
    tbl.push_back(mk(0, C_NOP, 0, 1, 32'h99, 1,     0, C_NONE, 32'h0,         0, 0, 0));
    tbl.push_back(mk(1, C_WR,  32'h5, 0, 0, 0,      1, C_ACK,  32'h0,         0, 0, 0));
    tbl.push_back(mk(1, C_ST,  0, 0, 0, 0,          1, C_STAT, 32'h0001_0000, 0, 0, 0));
    tbl.push_back(mk(1, C_RD,  0, 0, 0, 0,          1, C_ACK,  32'h5,         0, 0, 0));
    tbl.push_back(mk(1, C_RD,  0, 0, 0, 0,          1, C_NACK, 32'h0,         0, 0, 0));
    foreach (tbl[i]) run_vec(i, tbl[i]);
`else
    // Idle, NOP and ignored requests
    tbl.push_back(mk(1, C_ST,  0, 0, 0, 0,          1, C_STAT, 32'h0000_0002, 0, 0, 1));
    tbl.push_back(mk(1, C_NOP, 32'hFFFF, 0, 0, 0,   0, C_NONE, 32'h0,         0, 0, 1));
    tbl.push_back(mk(0, C_WR,  32'h77, 0, 0, 0,     0, C_NONE, 32'h0,         0, 0, 1));
    // Source fills ingress, three back-to-back READs
    tbl.push_back(mk(0, C_NOP, 0, 1, 32'hDEAD_BEEF, 0, 0, C_NONE, 32'h0,      0, 0, 1));
    tbl.push_back(mk(0, C_NOP, 0, 1, 32'h0000_1000, 0, 0, C_NONE, 32'h0,      0, 0, 1));
    tbl.push_back(mk(1, C_RD,  0, 0, 0, 0,          1, C_ACK,  32'hDEAD_BEEF, 0, 0, 1));
    tbl.push_back(mk(1, C_RD,  0, 0, 0, 0,          1, C_ACK,  32'h0000_1000, 0, 0, 1));
    tbl.push_back(mk(1, C_RD,  0, 0, 0, 0,          1, C_NACK, 32'h0,         0, 0, 1));
    tbl.push_back(mk(1, C_ST,  0, 0, 0, 0,          1, C_STAT, 32'h0000_0002, 0, 0, 1));
    // Fill egress: 8 ACKs then NACK
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1, C_WR, 32'(i), 0, 0, 0,    1, C_ACK,  32'h0,         1, 32'h1, 1));
    tbl.push_back(mk(1, C_WR,  32'h9, 0, 0, 0,      1, C_NACK, 32'h0,         1, 32'h1, 1));
    tbl.push_back(mk(1, C_ST,  0, 0, 0, 0,          1, C_STAT, 32'h0000_0803, 1, 32'h1, 1));
    // WRITE on full egress while sink pops: still NACK
    tbl.push_back(mk(1, C_WR,  32'hA, 0, 0, 1,      1, C_NACK, 32'h0,         1, 32'h2, 1));
    tbl.push_back(mk(1, C_ST,  0, 0, 0, 0,          1, C_STAT, 32'h0000_0702, 1, 32'h2, 1));
    // Drain remaining in order; 0xA must never appear
    for (int k = 3; k <= 8; k++)
      tbl.push_back(mk(0, C_NOP, 0, 0, 0, 1,        0, C_NONE, 32'h0,         1, 32'(k), 1));
    tbl.push_back(mk(0, C_NOP, 0, 0, 0, 1,          0, C_NONE, 32'h0,         0, 32'h0, 1));
    tbl.push_back(mk(0, C_NOP, 0, 0, 0, 1,          0, C_NONE, 32'h0,         0, 32'h0, 1));
    // Ingress to 3 entries, then push+pop in one cycle
    tbl.push_back(mk(0, C_NOP, 0, 1, 32'h11, 0,     0, C_NONE, 32'h0,         0, 0, 1));
    tbl.push_back(mk(0, C_NOP, 0, 1, 32'h22, 0,     0, C_NONE, 32'h0,         0, 0, 1));
    tbl.push_back(mk(0, C_NOP, 0, 1, 32'h33, 0,     0, C_NONE, 32'h0,         0, 0, 1));
    tbl.push_back(mk(1, C_RD,  0, 1, 32'h44, 0,     1, C_ACK,  32'h11,        0, 0, 1));
    tbl.push_back(mk(1, C_ST,  0, 0, 0, 0,          1, C_STAT, 32'h0003_0000, 0, 0, 1));
    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Pointer wraparound: 20 cycles of simultaneous push and READ
    model = '{32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 20; i++) begin
      logic [31:0] exp_d;
      exp_d = model.pop_front();
      model.push_back(32'h100 + 32'(i));
      drive(1'b1, C_RD, 32'h0, 1'b1, 32'h100 + 32'(i), 1'b0);
      chk_rsp($sformatf("wrap%0d", i), 1'b1, C_ACK, exp_d);
    end
    drive(1'b1, C_ST, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rsp("wrap_status", 1'b1, C_STAT, 32'h0003_0000);

    // Build up a burst, then reset asynchronously mid-operation
    drive(1'b0, C_NOP, 32'h0, 1'b1, 32'h200, 1'b0);
    model.push_back(32'h200);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, C_WR, 32'hB0 + 32'(i), 1'b0, 32'h0, 1'b0);
      chk_rsp($sformatf("burst_wr%0d", i), 1'b1, C_ACK, 32'h0);
    end
    drive(1'b1, C_RD, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rsp("burst_rd", 1'b1, C_ACK, model[0]);
    to_peripheral_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_rsp("async_reset_rsp", 1'b0, C_NONE, 32'h0);
    chk("async_reset_port", {30'd0, snk_valid, snk_data, src_ready}, {30'd0, 1'b0, 32'h0, 1'b1});
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, C_ST, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rsp("post_reset_status", 1'b1, C_STAT, 32'h0000_0002);
    drive(1'b0, C_NOP, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_rsp("single_cycle_valid", 1'b0, C_NONE, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
